// File: rtl/acsp_pkg.sv
// Shared types for the ACSP host command parser: opcodes, parser states, frame layout.
// The optional checksum byte (ACSP_CMD_CHECKSUM_EN) adds the CHK state and the checksum helper.
package acsp_pkg;

    typedef enum logic [7:0] {
        OP_NOP       = 8'h00,
        OP_RESET     = 8'h01,
        OP_ARM       = 8'h02,
        OP_TRIGGER   = 8'h03,
        OP_SET_RATE  = 8'h04,
        OP_SET_DEPTH = 8'h05,
        OP_READ      = 8'h06,
        OP_STATUS    = 8'h07
    } opcode_t;

    localparam int FRAME_ARG_BYTES = 4;

`ifdef ACSP_CMD_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_PENDING,
        ST_CHK
    } state_t;

    // Expected trailer byte: XOR of the opcode and all four argument bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0] opcode,
                                                  input logic [31:0] arg);
        return opcode ^ arg[7:0] ^ arg[15:8] ^ arg[23:16] ^ arg[31:24];
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_PENDING
    } state_t;
`endif

endpackage

// File: rtl/acsp_cmd_parser_if.sv
// Byte-stream input and decoded-command output bundle of the ACSP command parser.
// The err_checksum strobe exists only when ACSP_CMD_CHECKSUM_EN is defined.
interface acsp_cmd_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_bad_opcode;
    logic        err_timeout;
    logic        err_overrun;
`ifdef ACSP_CMD_CHECKSUM_EN
    logic        err_checksum;

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_opcode, cmd_arg, cmd_valid,
        input  err_bad_opcode, err_timeout, err_overrun, err_checksum
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_opcode, cmd_arg, cmd_valid,
        output err_bad_opcode, err_timeout, err_overrun, err_checksum
    );
`else
    // The upstream side (UART receiver plus command consumer) is the master.
    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_opcode, cmd_arg, cmd_valid,
        input  err_bad_opcode, err_timeout, err_overrun
    );

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_opcode, cmd_arg, cmd_valid,
        output err_bad_opcode, err_timeout, err_overrun
    );
`endif
endinterface

// File: rtl/acsp_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags when
// TIMEOUT_CYCLES is reached; the count restarts on clear, expiry or when disabled.
module acsp_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 250_000
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = enable && (count_q == W'(TIMEOUT_CYCLES));

    always_comb begin
        count_d = count_q + W'(1);
        if (clear || !enable || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/acsp_cmd_parser.sv
// Assembles opcode + 4 LSB-first argument bytes into a command with a valid/ready handshake.
// ACSP_CMD_CHECKSUM_EN adds a trailing XOR checksum byte checked in the CHK state.
module acsp_cmd_parser
    import acsp_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 250_000,
    parameter logic [7:0] MAX_OPCODE     = OP_STATUS
) (
    input  logic             system_clock,
    input  logic             reset_n,
    acsp_cmd_parser_if.slave bus
);

    localparam logic [1:0] LAST_ARG_IDX = 2'(FRAME_ARG_BYTES - 1);

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] arg_q, arg_d;
    logic        valid_q, valid_d;
    logic        err_bad_q, err_bad_d;
    logic        err_to_q, err_to_d;
    logic        err_ovr_q, err_ovr_d;
    logic        take_opcode;
    logic        timer_en;
    logic        timer_expired;
`ifdef ACSP_CMD_CHECKSUM_EN
    logic        err_chk_q, err_chk_d;

    assign timer_en = (state_q == ST_ARG) || (state_q == ST_CHK);
    assign bus.err_checksum = err_chk_q;
`else
    assign timer_en = (state_q == ST_ARG);
`endif

    acsp_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .system_clock(system_clock),
        .reset_n     (reset_n),
        .clear       (bus.rx_valid),
        .enable      (timer_en),
        .expired     (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        opcode_d    = opcode_q;
        arg_d       = arg_q;
        valid_d     = valid_q;
        err_bad_d   = 1'b0;
        err_to_d    = 1'b0;
        err_ovr_d   = 1'b0;
        take_opcode = 1'b0;
`ifdef ACSP_CMD_CHECKSUM_EN
        err_chk_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: take_opcode = bus.rx_valid;

            ST_ARG: begin
                // An arriving byte beats a simultaneous timer expiry.
                if (bus.rx_valid) begin
                    arg_d[8*byte_idx_q +: 8] = bus.rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_ARG_IDX) begin
`ifdef ACSP_CMD_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_PENDING;
                        valid_d = 1'b1;
`endif
                    end
                end else if (timer_expired) begin
                    state_d    = ST_IDLE;
                    err_to_d   = 1'b1;
                    opcode_d   = '0;
                    arg_d      = '0;
                    byte_idx_d = '0;
                end
            end

`ifdef ACSP_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == frame_checksum(opcode_q, arg_q)) begin
                        state_d = ST_PENDING;
                        valid_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        err_chk_d = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d  = ST_IDLE;
                    err_to_d = 1'b1;
                    opcode_d = '0;
                    arg_d    = '0;
                end
            end
`endif

            ST_PENDING: begin
                // A byte arriving with the handshake starts the next frame immediately.
                if (bus.cmd_ready) begin
                    valid_d     = 1'b0;
                    state_d     = ST_IDLE;
                    take_opcode = bus.rx_valid;
                end else if (bus.rx_valid) begin
                    err_ovr_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (take_opcode) begin
            if (bus.rx_data <= MAX_OPCODE) begin
                opcode_d   = bus.rx_data;
                arg_d      = '0;
                byte_idx_d = '0;
                state_d    = ST_ARG;
            end else begin
                err_bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            opcode_q   <= '0;
            arg_q      <= '0;
            valid_q    <= 1'b0;
            err_bad_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovr_q  <= 1'b0;
`ifdef ACSP_CMD_CHECKSUM_EN
            err_chk_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            opcode_q   <= opcode_d;
            arg_q      <= arg_d;
            valid_q    <= valid_d;
            err_bad_q  <= err_bad_d;
            err_to_q   <= err_to_d;
            err_ovr_q  <= err_ovr_d;
`ifdef ACSP_CMD_CHECKSUM_EN
            err_chk_q  <= err_chk_d;
`endif
        end
    end

    assign bus.cmd_opcode     = opcode_q;
    assign bus.cmd_arg        = arg_q;
    assign bus.cmd_valid      = valid_q;
    assign bus.err_bad_opcode = err_bad_q;
    assign bus.err_timeout    = err_to_q;
    assign bus.err_overrun    = err_ovr_q;

endmodule
